// File: rtl/skew_buffer_pp.sv
// rtl/skew_buffer_pp.sv - ping-pong operand tile buffer with diagonally skewed drain
module skew_buffer_pp #(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 8,
  parameter int K_DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic signed [DATA_WIDTH-1:0] wr_data [ARRAY_SIZE],
  input  logic                         rd_enable,
  input  logic                         skew_en,
  output logic signed [DATA_WIDTH-1:0] data_out [ARRAY_SIZE],
  output logic        [ARRAY_SIZE-1:0] valid_out,
  output logic                         tile_done,
  output logic                         busy
);
  localparam int CNT_W = $clog2(K_DEPTH + ARRAY_SIZE);
  localparam int COL_W = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
  // Index of the final drain step in each mode.
  localparam logic [CNT_W-1:0] LAST_SKEW  = CNT_W'(K_DEPTH + ARRAY_SIZE - 2);
  localparam logic [CNT_W-1:0] LAST_ALIGN = CNT_W'(K_DEPTH - 1);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(K_DEPTH - 1);
  localparam logic [CNT_W-1:0] K_CNT      = CNT_W'(K_DEPTH);

  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nx;

  logic signed [DATA_WIDTH-1:0] bank [2][ARRAY_SIZE][K_DEPTH];
  logic [1:0]       bank_full;
  logic             wr_bank, rd_bank;
  logic [COL_W-1:0] wr_col;
  logic [CNT_W-1:0] rd_cnt;
  logic             skew_q;

  logic             wr_accept, drain_step, last_step, drain_start;
  logic [CNT_W-1:0] last_cnt, lane_off, lane_e;
  logic signed [DATA_WIDTH-1:0] lane_data [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0]        lane_valid;

  assign wr_ready  = !bank_full[wr_bank];
  assign wr_accept = wr_valid && wr_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bank_full[rd_bank]) state_nx = DRAIN;
        DRAIN:   if (last_step && !bank_full[~rd_bank]) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state == DRAIN);
    drain_step  = busy && rd_enable;
    last_cnt    = skew_q ? LAST_SKEW : LAST_ALIGN;
    last_step   = drain_step && (rd_cnt == last_cnt);
    drain_start = (state == IDLE) && bank_full[rd_bank];
  end

  // Lane i reads element rd_cnt - i in skewed mode; out-of-window slots read 0.
  always_comb begin
    lane_off = '0;
    lane_e   = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      lane_off      = skew_q ? CNT_W'(i) : '0;
      lane_e        = rd_cnt - lane_off;
      lane_valid[i] = (rd_cnt >= lane_off) && (lane_e < K_CNT);
      lane_data[i]  = lane_valid[i] ? bank[rd_bank][i][lane_e[COL_W-1:0]] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      wr_col    <= '0;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      skew_q    <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < ARRAY_SIZE; i++)
          for (int k = 0; k < K_DEPTH; k++)
            bank[b][i][k] <= '0;
    end else if (flush) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      wr_col    <= '0;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      skew_q    <= 1'b0;
    end else begin
      if (wr_accept) begin
        for (int i = 0; i < ARRAY_SIZE; i++)
          bank[wr_bank][i][wr_col] <= wr_data[i];
        if (wr_col == LAST_COL) begin
          wr_col             <= '0;
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      // Write and release always target different banks, so both updates stand.
      if (drain_start) begin
        rd_cnt <= '0;
        skew_q <= skew_en;
      end else if (last_step) begin
        rd_cnt             <= '0;
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
        skew_q             <= skew_en;
      end else if (drain_step) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARRAY_SIZE; i++) data_out[i] <= '0;
      valid_out <= '0;
      tile_done <= 1'b0;
    end else if (flush || state == IDLE) begin
      for (int i = 0; i < ARRAY_SIZE; i++) data_out[i] <= '0;
      valid_out <= '0;
      tile_done <= 1'b0;
    end else if (rd_enable) begin
      data_out  <= lane_data;
      valid_out <= lane_valid;
      tile_done <= last_step;
    end else begin
      tile_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_skew_buffer_pp.sv
// tb/tb_skew_buffer_pp.sv - directed self-checking bench for skew_buffer_pp
module tb_skew_buffer_pp;
  localparam int AS = 4;
  localparam int DW = 8;
  localparam int KD = 4;

  logic clk = 1'b0;
  logic rst_n, flush, wr_valid, wr_ready, rd_enable, skew_en, tile_done, busy;
  logic signed [DW-1:0] wr_data  [AS];
  logic signed [DW-1:0] data_out [AS];
  logic [AS-1:0]        valid_out;
  int checks = 0;
  int errors = 0;

  skew_buffer_pp #(.ARRAY_SIZE(AS), .DATA_WIDTH(DW), .K_DEPTH(KD)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_enable(rd_enable), .skew_en(skew_en), .data_out(data_out),
    .valid_out(valid_out), .tile_done(tile_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Tile contents: 0 = 10*i+k, 1 = 50+10*i+k, 2 = alternating -128 / 127.
  function automatic logic signed [7:0] val(input int kind, input int i, input int k);
    case (kind)
      0:       return 8'(10 * i + k);
      1:       return 8'(50 + 10 * i + k);
      default: return ((i + k) % 2 == 0) ? 8'h80 : 8'h7F;
    endcase
  endfunction

  task automatic check_step(input string tag, input int kind, input bit skew, input int s, input logic done);
    for (int i = 0; i < AS; i++) begin
      int e;
      logic signed [7:0] ed;
      logic ev;
      e = s - (skew ? i : 0);
      if (e >= 0 && e < KD) begin
        ed = val(kind, i, e);
        ev = 1'b1;
      end else begin
        ed = 8'sd0;
        ev = 1'b0;
      end
      chk($sformatf("%s s%0d lane%0d data", tag, s, i), data_out[i], ed);
      chk($sformatf("%s s%0d lane%0d valid", tag, s, i), valid_out[i], ev);
    end
    chk($sformatf("%s s%0d tile_done", tag, s), tile_done, done);
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < AS; i++)
      chk($sformatf("%s lane%0d data", tag, i), data_out[i], 0);
    chk({tag, " valid_out"}, valid_out, 0);
    chk({tag, " tile_done"}, tile_done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " wr_ready"}, wr_ready, 1);
  endtask

  task automatic write_tile(input int kind);
    for (int k = 0; k < KD; k++) begin
      chk($sformatf("write k%0d wr_ready", k), wr_ready, 1);
      wr_valid = 1'b1;
      for (int i = 0; i < AS; i++) wr_data[i] = val(kind, i, k);
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < AS; i++) wr_data[i] = '0;
  endtask

  task automatic drain_tile(input string tag, input int kind, input bit skew);
    int last;
    last = skew ? KD + AS - 2 : KD - 1;
    tick();
    chk({tag, " entered busy"}, busy, 1);
    chk({tag, " entered valid_out"}, valid_out, 0);
    for (int s = 0; s <= last; s++) begin
      tick();
      check_step(tag, kind, skew, s, s == last);
    end
    tick();
    check_idle({tag, " back to idle"});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_enable = 1'b1; skew_en = 1'b1;
    for (int i = 0; i < AS; i++) wr_data[i] = '0;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;

    // Skewed drain
    skew_en = 1'b1;
    write_tile(0);
    chk("skew busy before drain", busy, 0);
    drain_tile("skew", 0, 1'b1);

    // Aligned drain
    skew_en = 1'b0;
    write_tile(0);
    drain_tile("align", 0, 1'b0);

    // Ping-pong: tiles A and B written back to back
    skew_en = 1'b1;
    for (int n = 0; n < 8; n++) begin
      chk($sformatf("pp beat%0d wr_ready", n), wr_ready, 1);
      wr_valid = 1'b1;
      for (int i = 0; i < AS; i++) wr_data[i] = val((n < 4) ? 0 : 1, i, n % 4);
      tick();
      if (n >= 5) check_step("pp A", 0, 1'b1, n - 5, 1'b0);
    end
    wr_valid = 1'b0;
    chk("pp wr_ready after 8 beats", wr_ready, 0);
    for (int n = 8; n < 12; n++) begin
      tick();
      check_step("pp A", 0, 1'b1, n - 5, n == 11);
      chk($sformatf("pp edge%0d wr_ready", n), wr_ready, n == 11);
    end
    chk("pp busy at handoff", busy, 1);
    for (int s = 0; s < KD + AS - 1; s++) begin
      tick();
      check_step("pp B", 1, 1'b1, s, s == KD + AS - 2);
    end
    tick();
    check_idle("pp end");

    // Stall three cycles at step 2
    write_tile(0);
    tick();
    chk("stall busy", busy, 1);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_step("stall", 0, 1'b1, s, 1'b0);
    end
    rd_enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_step($sformatf("stall hold%0d", c), 0, 1'b1, 2, 1'b0);
    end
    rd_enable = 1'b1;
    for (int s = 3; s < KD + AS - 1; s++) begin
      tick();
      check_step("stall resume", 0, 1'b1, s, s == KD + AS - 2);
    end
    tick();
    check_idle("stall end");

    // Flush at step 3
    write_tile(0);
    tick();
    for (int s = 0; s < 4; s++) begin
      tick();
      check_step("pre-flush", 0, 1'b1, s, 1'b0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_idle("flush");
    tick();
    check_idle("post-flush");
    write_tile(1);
    drain_tile("after flush", 1, 1'b1);

    // Reset at step 1
    write_tile(0);
    tick();
    for (int s = 0; s < 2; s++) begin
      tick();
      check_step("pre-reset", 0, 1'b1, s, 1'b0);
    end
    rst_n = 1'b0;
    tick();
    check_idle("reset mid-drain");
    rst_n = 1'b1;
    tick();
    check_idle("post-reset");

    // Extreme signed values
    write_tile(2);
    drain_tile("neg", 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
